// File: rtl/mul_div_unit_pkg.sv
// rtl/mul_div_unit_pkg.sv - RV32M op-codes, FSM encodings and operand-sign helpers
package mul_div_unit_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 6;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef logic [1:0] md_state_t;
  localparam md_state_t S_IDLE = 2'd0;
  localparam md_state_t S_RUN  = 2'd1;
  localparam md_state_t S_DONE = 2'd2;

  function automatic logic op_is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic op_signed_a(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_MULHSU) ||
           (f == MD_DIV) || (f == MD_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

endpackage

// File: rtl/md_negate.sv
// rtl/md_negate.sv - conditional two's-complement negation of a W-bit value
module md_negate #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN  = MD_XLEN,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_en
);

  md_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic [2:0]        r_funct3;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [4:0]        r_rd_pend;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  logic              w_s1;
  logic              w_s2;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic              w_div_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_val;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_sh;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_diff;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_s1 = op_signed_a(funct3) & rs1_data[XLEN-1];
  assign w_s2 = op_signed_b(funct3) & rs2_data[XLEN-1];

  md_negate #(.W(XLEN)) u_mag_a (.i_neg(w_s1), .i_val(rs1_data), .o_val(w_mag_a));
  md_negate #(.W(XLEN)) u_mag_b (.i_neg(w_s2), .i_val(rs2_data), .o_val(w_mag_b));

  assign w_div_zero = op_is_div(funct3) && (rs2_data == '0);
  assign w_ovf      = ((funct3 == MD_DIV) || (funct3 == MD_REM)) &&
                      (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign w_special  = w_div_zero | w_ovf;

  // funct3[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_special_val = '0;
    if (w_div_zero) begin
      w_special_val = funct3[1] ? rs1_data : '1;
    end else if (w_ovf) begin
      w_special_val = funct3[1] ? '0 : rs1_data;
    end
  end

  // Multiply: r_acc = {partial product, remaining multiplier bits}, shifts right.
  // Divide:   r_acc = {partial remainder, dividend/quotient bits}, shifts left.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_div_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_ge   = w_div_sh >= {1'b0, r_opb};
  assign w_div_diff = w_div_sh[XLEN-1:0] - r_opb;

  always_comb begin
    w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
    if (op_is_div(r_funct3)) begin
      w_acc_next = w_div_ge ? {w_div_diff, r_acc[XLEN-2:0], 1'b1}
                            : {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end
  end

  md_negate #(.W(2*XLEN)) u_fix_prod (.i_neg(r_neg_q), .i_val(w_acc_next), .o_val(w_prod));
  md_negate #(.W(XLEN)) u_fix_quot (.i_neg(r_neg_q), .i_val(w_acc_next[XLEN-1:0]), .o_val(w_quot));
  md_negate #(.W(XLEN)) u_fix_rem (.i_neg(r_neg_r), .i_val(w_acc_next[2*XLEN-1:XLEN]), .o_val(w_rem));

  always_comb begin
    w_final = w_rem;
    case (r_funct3)
      MD_MUL:                       w_final = w_prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              w_final = w_quot;
      default:                      w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_funct3  <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rd_pend <= '0;
      r_result  <= '0;
      r_rd_out  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_special) begin
              r_state  <= S_DONE;
              r_result <= w_special_val;
              r_rd_out <= rd_in;
            end else begin
              r_state   <= S_RUN;
              r_cnt     <= '0;
              r_acc     <= {{XLEN{1'b0}}, (op_is_div(funct3) ? w_mag_a : w_mag_b)};
              r_opb     <= op_is_div(funct3) ? w_mag_b : w_mag_a;
              r_funct3  <= funct3;
              r_neg_q   <= w_s1 ^ w_s2;
              r_neg_r   <= w_s1;
              r_rd_pend <= rd_in;
            end
          end
        end
        S_RUN: begin
          if (kill) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (r_cnt == CNT_W'(XLEN - 1)) begin
              r_state  <= S_DONE;
              r_result <= w_final;
              r_rd_out <= r_rd_pend;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign rd_out = r_rd_out;
  assign wb_en  = done & (r_rd_out != 5'd0);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized and directed bench for mul_div_unit against an arithmetic model
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in), .kill(kill),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wb_en(wb_en)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    case (f)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      MD_MULHU:  begin p = ua * ub; return p[63:32]; end
      MD_DIV:    begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      MD_DIVU:   begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      MD_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Cycle-level expectation: special ops finish at the accepting edge, others 32 edges later.
  logic        m_init = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pend_res = 32'd0;
  logic [4:0]  m_rd = 5'd0;
  logic [4:0]  m_pend_rd = 5'd0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_init <= 1'b1; m_busy <= 1'b0; m_done <= 1'b0;
      m_result <= 32'd0; m_rd <= 5'd0; m_left <= 0;
    end else if (m_done) begin
      m_done <= 1'b0; m_busy <= 1'b0;
    end else if (m_busy) begin
      if (kill) m_busy <= 1'b0;
      else if (m_left == 1) begin
        m_done <= 1'b1; m_result <= m_pend_res; m_rd <= m_pend_rd;
      end else m_left <= m_left - 1;
    end else if (start) begin
      m_busy <= 1'b1;
      if (is_special(funct3, rs1_data, rs2_data)) begin
        m_done <= 1'b1; m_result <= ref_model(funct3, rs1_data, rs2_data); m_rd <= rd_in;
      end else begin
        m_left <= 32; m_pend_res <= ref_model(funct3, rs1_data, rs2_data); m_pend_rd <= rd_in;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cyc_busy", busy, m_busy);
      chk("cyc_done", done, m_done);
      chk("cyc_wb_en", wb_en, m_done && (m_rd != 5'd0));
      chk("cyc_result", result, m_result);
      chk("cyc_rd_out", rd_out, m_rd);
    end
  end

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int g;
    g = 0;
    while (busy && g < 100) begin @(posedge clk); #1; g++; end
    @(negedge clk);
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // hook_kind: 0 none, 1 extra start, 2 reset, 3 kill; driven for one cycle once n == hook_cyc
  task automatic wait_done(input int hook_cyc, input int hook_kind, output int n);
    n = 1;
    while (!done && n < 60) begin
      if (n == hook_cyc) begin
        case (hook_kind)
          1: begin start = 1'b1; funct3 = MD_DIVU; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd9; end
          2: reset = 1'b1;
          3: kill = 1'b1;
          default: ;
        endcase
      end
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0; reset = 1'b0;
      if (n == hook_cyc && hook_kind >= 2) break;
      n++;
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int exp_lat, input string name);
    int n;
    launch(f, a, b, rd);
    wait_done(0, 0, n);
    chk({name, "_lat"}, n, exp_lat);
    chk({name, "_res"}, result, exp);
    chk({name, "_rd"}, rd_out, rd);
    chk({name, "_wb"}, wb_en, rd != 5'd0);
  endtask

  task automatic watch_no_done(input string name);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) pulses++; end
    chk(name, pulses, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          kind;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_result", result, 0);
    chk("rst_rd_out", rd_out, 0);
    reset = 1'b0;

    run_op(MD_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, "mul_7_m3");
    run_op(MD_MULH,   32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 33, "mulh_min");
    run_op(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33, "mulhu_max");
    run_op(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 33, "mulhsu_m1");
    run_op(MD_DIV,    32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFD, 33, "div_m7_2");
    run_op(MD_REM,    32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 33, "rem_m7_2");
    run_op(MD_DIVU,   32'hFFFFFFFE, 32'd2,        5'd7,  32'h7FFFFFFF, 33, "divu_big");
    run_op(MD_DIV,    32'd100,      32'd10,       5'd0,  32'd10,       33, "div_rd0");
    run_op(MD_DIV,    32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, 1,  "div_by0");
    run_op(MD_REMU,   32'd5,        32'd0,        5'd8,  32'd5,        1,  "remu_by0");
    run_op(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1,  "div_ovf");
    run_op(MD_REM,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        1,  "rem_ovf");

    launch(MD_MUL, 32'd1234, 32'd5678, 5'd12);
    wait_done(10, 1, n);
    chk("restart_lat", n, 33);
    chk("restart_res", result, 32'd7006652);

    launch(MD_DIV, 32'd1000, 32'd3, 5'd13);
    wait_done(12, 2, n);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_result", result, 0);
    watch_no_done("midreset_no_done");

    run_op(MD_DIVU, 32'd100, 32'd7, 5'd14, 32'd14, 33, "divu_100_7");

    launch(MD_REM, 32'd1000, 32'd7, 5'd15);
    wait_done(20, 3, n);
    chk("kill20_busy", busy, 0);
    chk("kill20_result", result, 32'd14);
    watch_no_done("kill20_no_done");

    launch(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16);
    wait_done(32, 3, n);
    chk("killlast_done", done, 0);
    chk("killlast_busy", busy, 0);
    chk("killlast_result", result, 32'd14);
    watch_no_done("killlast_no_done");

    for (int i = 0; i < 150; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      rd = 5'($urandom_range(0, 31));
      kind = ($urandom_range(0, 7) == 0) ? 3 : (($urandom_range(0, 9) == 0) ? 1 : 0);
      launch(f, a, b, rd);
      wait_done((kind != 0) ? $urandom_range(1, 33) : 0, kind, n);
    end

    repeat (40) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
